// File: rtl/nettlp_udp_rx.sv
// nettlp_udp_rx: validates NetTLP Ethernet/IPv4/UDP headers and forwards the TLP payload stream
module nettlp_udp_rx (
  input  logic        eth_clk,
  input  logic        eth_rst_n,
  input  logic        eth_rx_tvalid,
  output logic        eth_rx_tready,
  input  logic [63:0] eth_rx_tdata,
  input  logic [7:0]  eth_rx_tkeep,
  input  logic        eth_rx_tlast,
  input  logic        eth_rx_tuser,
  input  logic [47:0] adapter_reg_srcmac,
  input  logic [31:0] adapter_reg_srcip,
  input  logic [15:0] adapter_reg_srcport,
  output logic        tlp_tvalid,
  input  logic        tlp_tready,
  output logic [63:0] tlp_tdata,
  output logic [7:0]  tlp_tkeep,
  output logic        tlp_tlast,
  output logic        tlp_tuser,
  output logic        meta_valid,
  output logic [15:0] meta_seq,
  output logic [31:0] meta_tstamp,
  output logic [31:0] meta_srcip,
  output logic [15:0] meta_srcport,
  output logic [31:0] cnt_ok,
  output logic [31:0] cnt_drop
);
  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
  state_t      state_q;
  logic [2:0]  beat_q;
  logic        pass_q;
  logic        rdy_q;
  logic [31:0] sip_q;
  logic [15:0] sport_q;
  logic [63:0] w;
  logic        beat_ok;
  logic        pass_d;
  logic        acc;
  // byte-reverse the beat so header fields read as big-endian slices
  for (genvar i = 0; i < 8; i++) begin : g_swap
    assign w[63-8*i -: 8] = eth_rx_tdata[8*i +: 8];
  end
  // per-beat header checks; the port compare folds in the ignored low nibble so both sides match
  always_comb begin
    beat_ok = beat_q == 3'd0 ? w[63:16] == adapter_reg_srcmac :
              beat_q == 3'd1 ? w[31:16] == 16'h0800 && w[15:8] == 8'h45 :
              beat_q == 3'd2 ? w[7:0] == 8'h11 :
              beat_q == 3'd3 ? w[15:0] == adapter_reg_srcip[31:16] :
              beat_q == 3'd4 ? w[63:48] == adapter_reg_srcip[15:0] &&
                               {w[31:20], adapter_reg_srcport[3:0]} == adapter_reg_srcport :
              1'b1;
    pass_d = (beat_q == 3'd0 || pass_q) && beat_ok;
    eth_rx_tready = rdy_q && (state_q != PAYLOAD || !tlp_tvalid || tlp_tready);
    acc = eth_rx_tvalid && eth_rx_tready;
  end
  // header parse / payload forward / drop FSM with registered outputs and counters
  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q      <= HDR;
      beat_q       <= 3'd0;
      pass_q       <= 1'b0;
      rdy_q        <= 1'b0;
      sip_q        <= 32'd0;
      sport_q      <= 16'd0;
      tlp_tvalid   <= 1'b0;
      tlp_tdata    <= 64'd0;
      tlp_tkeep    <= 8'd0;
      tlp_tlast    <= 1'b0;
      tlp_tuser    <= 1'b0;
      meta_valid   <= 1'b0;
      meta_seq     <= 16'd0;
      meta_tstamp  <= 32'd0;
      meta_srcip   <= 32'd0;
      meta_srcport <= 16'd0;
      cnt_ok       <= 32'd0;
      cnt_drop     <= 32'd0;
    end else begin
      rdy_q      <= 1'b1;
      meta_valid <= 1'b0;
      if (tlp_tready) tlp_tvalid <= 1'b0;
      if (acc) begin
        unique case (state_q)
          HDR: begin
            pass_q <= pass_d;
            if (beat_q == 3'd3) sip_q <= w[47:16];
            if (beat_q == 3'd4) sport_q <= w[47:32];
            if (eth_rx_tlast) begin
              cnt_drop <= cnt_drop + 32'd1;
              beat_q   <= 3'd0;
            end else if (!pass_d) begin
              state_q <= DROP;
              beat_q  <= 3'd0;
            end else if (beat_q == 3'd5) begin
              state_q      <= PAYLOAD;
              beat_q       <= 3'd0;
              meta_valid   <= 1'b1;
              meta_seq     <= w[47:32];
              meta_tstamp  <= w[31:0];
              meta_srcip   <= sip_q;
              meta_srcport <= sport_q;
            end else begin
              beat_q <= beat_q + 3'd1;
            end
          end
          PAYLOAD: begin
            tlp_tvalid <= 1'b1;
            tlp_tdata  <= eth_rx_tdata;
            tlp_tkeep  <= eth_rx_tkeep;
            tlp_tlast  <= eth_rx_tlast;
            tlp_tuser  <= eth_rx_tlast && eth_rx_tuser;
            if (eth_rx_tlast) begin
              cnt_ok  <= cnt_ok + 32'd1;
              state_q <= HDR;
            end
          end
          default: begin
            if (eth_rx_tlast) begin
              cnt_drop <= cnt_drop + 32'd1;
              state_q  <= HDR;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nettlp_udp_rx.sv
// tb_nettlp_udp_rx: table-driven and scoreboard bench for the NetTLP receive de-framer
module tb_nettlp_udp_rx;
  localparam logic [47:0] MAC  = 48'h001122334455;
  localparam logic [31:0] IP   = 32'hC0A80A01;
  localparam logic [15:0] PORT = 16'h3000;
  logic        eth_clk = 1'b0;
  logic        eth_rst_n = 1'b0;
  logic        eth_rx_tvalid = 1'b0;
  logic        eth_rx_tready;
  logic [63:0] eth_rx_tdata = 64'd0;
  logic [7:0]  eth_rx_tkeep = 8'd0;
  logic        eth_rx_tlast = 1'b0;
  logic        eth_rx_tuser = 1'b0;
  logic [47:0] adapter_reg_srcmac = MAC;
  logic [31:0] adapter_reg_srcip = IP;
  logic [15:0] adapter_reg_srcport = PORT;
  logic        tlp_tvalid;
  logic        tlp_tready = 1'b1;
  logic [63:0] tlp_tdata;
  logic [7:0]  tlp_tkeep;
  logic        tlp_tlast;
  logic        tlp_tuser;
  logic        meta_valid;
  logic [15:0] meta_seq;
  logic [31:0] meta_tstamp;
  logic [31:0] meta_srcip;
  logic [15:0] meta_srcport;
  logic [31:0] cnt_ok;
  logic [31:0] cnt_drop;

  nettlp_udp_rx dut (
    .eth_clk(eth_clk), .eth_rst_n(eth_rst_n),
    .eth_rx_tvalid(eth_rx_tvalid), .eth_rx_tready(eth_rx_tready),
    .eth_rx_tdata(eth_rx_tdata), .eth_rx_tkeep(eth_rx_tkeep),
    .eth_rx_tlast(eth_rx_tlast), .eth_rx_tuser(eth_rx_tuser),
    .adapter_reg_srcmac(adapter_reg_srcmac), .adapter_reg_srcip(adapter_reg_srcip),
    .adapter_reg_srcport(adapter_reg_srcport),
    .tlp_tvalid(tlp_tvalid), .tlp_tready(tlp_tready), .tlp_tdata(tlp_tdata),
    .tlp_tkeep(tlp_tkeep), .tlp_tlast(tlp_tlast), .tlp_tuser(tlp_tuser),
    .meta_valid(meta_valid), .meta_seq(meta_seq), .meta_tstamp(meta_tstamp),
    .meta_srcip(meta_srcip), .meta_srcport(meta_srcport),
    .cnt_ok(cnt_ok), .cnt_drop(cnt_drop)
  );

  typedef struct {logic [63:0] d; logic [7:0] k; logic l; logic u;} beat_t;
  typedef struct {logic [15:0] seq; logic [31:0] ts; logic [31:0] sip; logic [15:0] sp;} meta_t;
  typedef struct {logic [47:0] mac; logic [15:0] et; logic [7:0] pr; logic [31:0] dip;
                  logic [15:0] dp; int plen; bit tu; bit ok;} vec_t;

  beat_t      exp_q[$];
  meta_t      meta_q[$];
  logic [7:0] frm[$];
  meta_t      cur;
  vec_t       tbl[8];
  int checks = 0;
  int failures = 0;
  int ok_m = 0;
  int drop_m = 0;
  bit in_pay = 1'b0;
  bit chk_rdy = 1'b0;
  bit tog_en = 1'b0;

  initial forever #5 eth_clk = ~eth_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge eth_clk);
    #1;
  endtask

  task automatic pb(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input logic [47:0] dmac, input logic [15:0] et, input logic [7:0] pr,
                       input logic [31:0] dip, input logic [15:0] dp, input logic [15:0] seq,
                       input logic [31:0] ts, input int plen);
    frm.delete();
    cur.seq = seq;
    cur.ts  = ts;
    cur.sip = 32'h0A000002 + 32'($urandom_range(0, 200));
    cur.sp  = 16'($urandom);
    pb(dmac, 6);
    pb(48'h020000000001, 6);
    pb(48'(et), 2);
    pb(48'h45, 1);
    pb(48'h0, 7);
    pb(48'h40, 1);
    pb(48'(pr), 1);
    pb(48'h0, 2);
    pb(48'(cur.sip), 4);
    pb(48'(dip), 4);
    pb(48'(cur.sp), 2);
    pb(48'(dp), 2);
    pb(48'h0, 4);
    pb(48'(seq), 2);
    pb(48'(ts), 4);
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    logic r;
    eth_rx_tvalid = 1'b1;
    eth_rx_tdata  = d;
    eth_rx_tkeep  = k;
    eth_rx_tlast  = l;
    eth_rx_tuser  = u;
    for (int n = 0; n < 1000; n++) begin
      @(negedge eth_clk);
      r = eth_rx_tready;
      @(posedge eth_clk);
      #1;
      if (r) return;
    end
    chk("rx_accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input int stop, input bit ok, input bit tu);
    int nb;
    logic [63:0] d;
    logic [7:0] k;
    beat_t b;
    nb = (frm.size() + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      if (i == stop) return;
      d = 64'd0;
      k = 8'd0;
      for (int j = 0; j < 8; j++) begin
        if (i * 8 + j < frm.size()) begin
          d[8*j +: 8] = frm[i*8+j];
          k[j] = 1'b1;
        end
      end
      if (ok && i == 5) meta_q.push_back(cur);
      if (ok && i >= 6) begin
        b.d = d; b.k = k; b.l = (i == nb - 1); b.u = tu && (i == nb - 1);
        exp_q.push_back(b);
      end
      drive(d, k, i == nb - 1, tu && (i == nb - 1));
      if (ok && i == 5) in_pay = 1'b1;
    end
    in_pay = 1'b0;
    eth_rx_tvalid = 1'b0;
    eth_rx_tlast  = 1'b0;
    eth_rx_tuser  = 1'b0;
    if (ok) ok_m++;
    else drop_m++;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) cyc(1);
    chk("drain_timeout", 128'(exp_q.size()), 0);
    cyc(3);
    chk("cnt_ok", cnt_ok, ok_m);
    chk("cnt_drop", cnt_drop, drop_m);
  endtask

  // tlp_tready stall pattern 1,0,0,1 while enabled
  initial begin
    logic [3:0] pat;
    int tc;
    pat = 4'b1001;
    tc = 0;
    forever begin
      @(posedge eth_clk);
      #1;
      if (tog_en) begin
        tlp_tready = pat[tc % 4];
        tc++;
      end
    end
  end

  // output scoreboard, meta check, ready rule and stall-hold check
  initial begin
    beat_t e;
    meta_t m;
    logic [73:0] prev;
    bit stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge eth_clk);
      if (!eth_rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("stall_hold", {tlp_tuser, tlp_tlast, tlp_tkeep, tlp_tdata}, prev);
        stalled = tlp_tvalid && !tlp_tready;
        prev = {tlp_tuser, tlp_tlast, tlp_tkeep, tlp_tdata};
        if (tlp_tvalid && tlp_tready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", {tlp_tlast, tlp_tdata}, 0);
          else begin
            e = exp_q.pop_front();
            chk("tlp_beat", {tlp_tuser, tlp_tlast, tlp_tkeep, tlp_tdata}, {e.u, e.l, e.k, e.d});
          end
        end
        if (meta_valid) begin
          if (meta_q.size() == 0) chk("unexpected_meta", 1, 0);
          else begin
            m = meta_q.pop_front();
            chk("meta", {meta_seq, meta_tstamp, meta_srcip, meta_srcport}, {m.seq, m.ts, m.sip, m.sp});
          end
        end
        if (chk_rdy) chk("rx_tready", eth_rx_tready, in_pay ? (!tlp_tvalid || tlp_tready) : 1'b1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{MAC, 16'h0800, 8'h11, IP, 16'h3001, 12, 1'b0, 1'b1};
    tbl[1] = '{MAC, 16'h86DD, 8'h11, IP, 16'h3001, 16, 1'b0, 1'b0};
    tbl[2] = '{MAC, 16'h0800, 8'h11, 32'hC0A80A02, 16'h3001, 16, 1'b0, 1'b0};
    tbl[3] = '{MAC, 16'h0800, 8'h11, IP, 16'h4000, 16, 1'b0, 1'b0};
    tbl[4] = '{MAC ^ 48'h1, 16'h0800, 8'h11, IP, 16'h3001, 8, 1'b0, 1'b0};
    tbl[5] = '{MAC, 16'h0800, 8'h06, IP, 16'h3001, 8, 1'b0, 1'b0};
    tbl[6] = '{MAC, 16'h0800, 8'h11, IP, 16'h300F, 20, 1'b1, 1'b1};
    tbl[7] = '{MAC, 16'h0800, 8'h11, IP, 16'h3000, 3, 1'b0, 1'b1};
    cyc(3);
    chk("rst_rx_tready", eth_rx_tready, 0);
    chk("rst_tlp_tvalid", tlp_tvalid, 0);
    chk("rst_flags", {tlp_tlast, tlp_tuser, meta_valid}, 0);
    chk("rst_tdata_keep", {tlp_tkeep, tlp_tdata}, 0);
    chk("rst_meta", {meta_seq, meta_tstamp, meta_srcip, meta_srcport}, 0);
    chk("rst_cnt", {cnt_ok, cnt_drop}, 0);
    eth_rst_n = 1'b1;
    cyc(2);
    chk("ready_after_rst", eth_rx_tready, 1);
    chk_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      build(tbl[i].mac, tbl[i].et, tbl[i].pr, tbl[i].dip, tbl[i].dp,
            i == 0 ? 16'h0102 : 16'h0200 + 16'(i), i == 0 ? 32'hAABBCCDD : $urandom, tbl[i].plen);
      send_frame(-1, tbl[i].ok, tbl[i].tu);
      wait_idle();
    end
    build(MAC, 16'h0800, 8'h11, IP, 16'h3001, 16'h0300, 32'h01020304, 16);
    while (frm.size() > 32) void'(frm.pop_back());
    send_frame(-1, 1'b0, 1'b0);
    build(MAC, 16'h0800, 8'h11, IP, 16'h3001, 16'h0301, 32'h01020305, 16);
    while (frm.size() > 48) void'(frm.pop_back());
    send_frame(-1, 1'b0, 1'b0);
    build(MAC, 16'h0800, 8'h11, IP, 16'h3002, 16'h0302, 32'h01020306, 24);
    send_frame(-1, 1'b1, 1'b0);
    wait_idle();
    tog_en = 1'b1;
    build(MAC, 16'h0800, 8'h11, IP, 16'h3003, 16'h0400, 32'hCAFEF00D, 64);
    send_frame(-1, 1'b1, 1'b0);
    wait_idle();
    tog_en = 1'b0;
    tlp_tready = 1'b1;
    build(MAC, 16'h0800, 8'h11, IP, 16'h3004, 16'h0500, 32'h11111111, 10);
    send_frame(-1, 1'b1, 1'b0);
    build(MAC, 16'h0800, 8'h11, IP, 16'h3005, 16'h0501, 32'h22222222, 17);
    send_frame(-1, 1'b1, 1'b1);
    wait_idle();
    build(MAC, 16'h0800, 8'h11, IP, 16'h3006, 16'h0600, 32'h33333333, 64);
    send_frame(9, 1'b1, 1'b0);
    in_pay = 1'b0;
    chk_rdy = 1'b0;
    eth_rx_tvalid = 1'b1;
    eth_rx_tdata = 64'hDEADBEEF0BADF00D;
    eth_rx_tkeep = 8'hFF;
    eth_rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", tlp_tvalid, 0);
    chk("midrst_rx_tready", eth_rx_tready, 0);
    chk("midrst_out", {tlp_tlast, tlp_tuser, tlp_tkeep, tlp_tdata}, 0);
    chk("midrst_meta", {meta_seq, meta_tstamp}, 0);
    chk("midrst_cnt", {cnt_ok, cnt_drop}, 0);
    exp_q.delete();
    meta_q.delete();
    ok_m = 0;
    drop_m = 0;
    eth_rx_tvalid = 1'b0;
    cyc(2);
    eth_rst_n = 1'b1;
    cyc(2);
    chk_rdy = 1'b1;
    build(MAC, 16'h0800, 8'h11, IP, 16'h3007, 16'h0700, 32'h44444444, 20);
    send_frame(-1, 1'b1, 1'b0);
    wait_idle();
    chk("exp_q_empty", 128'(exp_q.size()), 0);
    chk("meta_q_empty", 128'(meta_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
